fetch_unit: RTL



---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word requests,
// pairs in-order responses with their PCs and buffers them for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misaligned
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
  logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [PTR_W-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;

  logic [31:0]  pcq_mem [BUF_DEPTH];
  fetch_entry_t buf_mem [BUF_DEPTH];

  logic         req_fire, pop, drop_rsp, push, pcq_push;
  logic         req_valid_d;
  fetch_entry_t push_entry, head_d;

  assign imem_req_addr = pc_q;

  // Next-state: PC, credit counters, queue pointers and next buffer head
  always_comb begin
    req_fire   = imem_req_valid & imem_req_ready;
    pop        = if_valid & if_ready;
    drop_rsp   = imem_rsp_valid & (drop_q != '0);
    push       = imem_rsp_valid & ~redirect_valid & (drop_q == '0);
    pcq_push   = req_fire & ~redirect_valid;
    push_entry = '{pc: pcq_mem[pcq_rd_q], instr: imem_rsp_data};

    pc_d      = pc_q;
    drop_d    = drop_q;
    buf_cnt_d = buf_cnt_q;
    pcq_rd_d  = pcq_rd_q;
    pcq_wr_d  = pcq_wr_q;
    buf_rd_d  = buf_rd_q;
    buf_wr_d  = buf_wr_q;

    // Credits return for every response, kept or dropped
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      drop_d    = inflight_d;
      buf_cnt_d = '0;
      pcq_rd_d  = '0;
      pcq_wr_d  = '0;
      buf_rd_d  = '0;
      buf_wr_d  = '0;
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + 32'd4;
        pcq_wr_d = pcq_wr_q + PTR_W'(1);
      end
      if (drop_rsp) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (push) begin
        buf_wr_d = buf_wr_q + PTR_W'(1);
        pcq_rd_d = pcq_rd_q + PTR_W'(1);
      end
      if (pop) begin
        buf_rd_d = buf_rd_q + PTR_W'(1);
      end
      buf_cnt_d = buf_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // The entry being written this cycle becomes the head if it lands at the new read slot
    head_d      = (push && (buf_rd_d == buf_wr_q)) ? push_entry : buf_mem[buf_rd_d];
    req_valid_d = (SUM_W'(inflight_d) + SUM_W'(buf_cnt_d)) < SUM_W'(BUF_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      inflight_q     <= '0;
      drop_q         <= '0;
      buf_cnt_q      <= '0;
      pcq_rd_q       <= '0;
      pcq_wr_q       <= '0;
      buf_rd_q       <= '0;
      buf_wr_q       <= '0;
      imem_req_valid <= 1'b0;
      if_valid       <= 1'b0;
      if_instr       <= '0;
      if_pc          <= '0;
      misaligned     <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      inflight_q     <= inflight_d;
      drop_q         <= drop_d;
      buf_cnt_q      <= buf_cnt_d;
      pcq_rd_q       <= pcq_rd_d;
      pcq_wr_q       <= pcq_wr_d;
      buf_rd_q       <= buf_rd_d;
      buf_wr_q       <= buf_wr_d;
      imem_req_valid <= req_valid_d;
      if_valid       <= (buf_cnt_d != '0);
      if_instr       <= head_d.instr;
      if_pc          <= head_d.pc;
      misaligned     <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
  end

  // Storage arrays: written only, never reset
  always_ff @(posedge clk) begin
    if (pcq_push) begin
      pcq_mem[pcq_wr_q] <= pc_q;
    end
    if (push) begin
      buf_mem[buf_wr_q] <= push_entry;
    end
  end

  // A response with nothing outstanding is a memory-side protocol error
  always_ff @(posedge clk) begin
    if (rst_n && imem_rsp_valid) begin
      assert (inflight_q != '0);
    end
  end

endmodule
